serial_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares one serial transmit path among NUM_REQ requesters.

---
 rtl/serial_tx_arbiter_if.sv | 25 ++
 rtl/serial_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_serial_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_arbiter_if.sv
// Requester and TX FIFO write-port signals shared by the arbiter and its neighbours.
// master: requesters plus FIFO side; slave: the arbiter.
interface serial_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_dv;
    logic                 tx_full;

    // Requester bytes move on a cycle where req_valid[i] and req_ready[i] are both high.
    // The FIFO takes one byte per cycle with tx_dv high; tx_dv is never high while tx_full is.
    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_data, tx_dv
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_data, tx_dv
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one serial TX FIFO, with an optional
// source-ID header byte and a watchdog that aborts a stalled packet.
module serial_tx_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter int         HDR_EN    = 1,
    parameter logic [3:0] HDR_TAG   = 4'hA,
    parameter int         STALL_MAX = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_tx_arbiter_if.slave  bus,
    output logic [3:0]          grant_id,
    output logic                busy,
    output logic                pkt_abort,
    output logic [1:0]          dbg_state,
    output logic [3:0]          dbg_ptr
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   ptr;
    logic [15:0]  stall_cnt;
    logic [15:0]  stall_inc;
    logic [IW-1:0] g;
    logic [3:0]   gid_inc;
    logic         found;
    logic [3:0]   pick;
    logic [4:0]   cand;
    logic         accept;
    logic         stall_hit;
    logic         pkt_end;
    logic [NUM_REQ-1:0] ready_c;
    logic [7:0]   data_c;
    logic         dv_c;
    logic [7:0]   data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign data_arr[i] = bus.req_data[8*i +: 8];
    end

    assign g         = grant_id[IW-1:0];
    assign gid_inc   = (grant_id == 4'(NUM_REQ - 1)) ? 4'd0 : grant_id + 4'd1;
    assign stall_inc = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;

    // First asserted requester searching upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = {1'b0, ptr} + 5'(j);
            if (cand >= 5'(NUM_REQ)) cand = cand - 5'(NUM_REQ);
            if (!found && bus.req_valid[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[3:0];
            end
        end
    end

    assign accept    = (state == DATA) && bus.req_valid[g] && !bus.tx_full;
    assign stall_hit = (state == DATA) && !bus.req_valid[g] && !bus.tx_full &&
                       (stall_inc == 16'(STALL_MAX));
    assign pkt_end   = accept && bus.req_last[g];

    always_comb begin
        state_next = state;
        ready_c    = '0;
        data_c     = 8'h00;
        dv_c       = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_next = (HDR_EN != 0) ? HDR : DATA;
            end
            HDR: begin
                data_c = {HDR_TAG, grant_id};
                dv_c   = !bus.tx_full;
                if (!bus.tx_full) state_next = DATA;
            end
            DATA: begin
                ready_c[g] = !bus.tx_full;
                data_c     = data_arr[g];
                dv_c       = accept;
                if (pkt_end || stall_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= 4'd0;
            ptr       <= 4'd0;
            stall_cnt <= 16'd0;
            pkt_abort <= 1'b0;
        end else begin
            state     <= state_next;
            pkt_abort <= stall_hit;
            if (state == IDLE && found) grant_id <= pick;
            if (pkt_end || stall_hit) ptr <= gid_inc;
            // Stall time only accrues while the FIFO could take a byte the requester withholds.
            if (state != DATA || accept || bus.tx_full) begin
                stall_cnt <= 16'd0;
            end else if (!bus.req_valid[g]) begin
                stall_cnt <= stall_inc;
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.tx_data   = data_c;
    assign bus.tx_dv     = dv_c;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;
    assign dbg_ptr       = ptr;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: one instance with header and short watchdog,
// one header-less instance for the pointer-wrap case.
module tb_serial_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_tx_arbiter_if #(.NUM_REQ(4)) a_if ();
    serial_tx_arbiter_if #(.NUM_REQ(4)) b_if ();

    logic [3:0] a_grant_id, b_grant_id, a_dbg_ptr, b_dbg_ptr;
    logic [1:0] a_dbg_state, b_dbg_state;
    logic       a_busy, b_busy, a_pkt_abort, b_pkt_abort;

    serial_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1), .HDR_TAG(4'hA), .STALL_MAX(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if), .grant_id(a_grant_id), .busy(a_busy),
        .pkt_abort(a_pkt_abort), .dbg_state(a_dbg_state), .dbg_ptr(a_dbg_ptr)
    );

    serial_tx_arbiter #(.NUM_REQ(4), .HDR_EN(0), .HDR_TAG(4'hA), .STALL_MAX(1023)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if), .grant_id(b_grant_id), .busy(b_busy),
        .pkt_abort(b_pkt_abort), .dbg_state(b_dbg_state), .dbg_ptr(b_dbg_ptr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int abort_seen = 0;
    logic [7:0] exp_q[$];

    logic [8:0] src_mem [4][16];
    int         src_rd [4];
    int         src_wr [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input logic [7:0] d, input logic l);
        src_mem[i][src_wr[i]] = {l, d};
        src_wr[i]++;
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                a_if.req_valid[i]        = 1'b1;
                a_if.req_data[8*i +: 8]  = src_mem[i][src_rd[i]][7:0];
                a_if.req_last[i]         = src_mem[i][src_rd[i]][8];
            end else begin
                a_if.req_valid[i]        = 1'b0;
                a_if.req_data[8*i +: 8]  = 8'h00;
                a_if.req_last[i]         = 1'b0;
            end
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++) if (src_rd[i] != src_wr[i]) e = 1'b0;
        return e;
    endfunction

    // Advance one clock: record handshakes mid-cycle, then present the next bytes after the edge.
    task automatic step();
        logic [3:0] fire;
        @(negedge clk);
        fire = a_if.req_valid & a_if.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i]) src_rd[i]++;
        drive();
        #1;
    endtask

    task automatic wait_done(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            done = !a_busy && all_empty();
        end
        check("done_in_budget", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        drive();
        a_if.tx_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard on the FIFO write port, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_if.tx_dv) begin
            if (exp_q.size() == 0) check("spurious_write", 32'(a_if.tx_dv), 32'd0);
            else check("tx_byte", 32'(a_if.tx_data), 32'(exp_q.pop_front()));
        end
        if (a_if.tx_full) check("full_quiet", 32'({a_if.tx_dv, a_if.req_ready}), 32'd0);
        if (a_pkt_abort) abort_seen++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        flush();
        drive();
        a_if.tx_full  = 1'b0;
        b_if.tx_full  = 1'b0;
        b_if.req_valid = '0;
        b_if.req_data  = '0;
        b_if.req_last  = '0;
        #2;
        check("rst_tx_dv", 32'(a_if.tx_dv), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_grant", 32'(a_grant_id), 32'd0);
        check("rst_abort", 32'(a_pkt_abort), 32'd0);
        check("rst_state", 32'(a_dbg_state), 32'd0);
        check("rst_ptr", 32'(a_dbg_ptr), 32'd0);
        do_reset();

        // Single packet from requester 2
        load(2, 8'h11, 1'b0);
        load(2, 8'h22, 1'b1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        step();
        check("t1_arb_busy", 32'(a_busy), 32'd0);
        check("t1_arb_dv", 32'(a_if.tx_dv), 32'd0);
        step();
        check("t1_hdr_busy", 32'(a_busy), 32'd1);
        check("t1_hdr_byte", 32'(a_if.tx_data), 32'hA2);
        step();
        step();
        check("t1_last_dv", 32'(a_if.tx_dv), 32'd1);
        check("t1_last_byte", 32'(a_if.tx_data), 32'h22);
        step();
        check("t1_busy_fall", 32'(a_busy), 32'd0);
        check("t1_grant", 32'(a_grant_id), 32'd2);
        wait_done(4);

        // Round robin across all four, requester 0 with a second packet
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 8'(8'h50 + i), 1'b1);
        load(0, 8'h60, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'hA0 + i));
            exp_q.push_back(8'(8'h50 + i));
        end
        exp_q.push_back(8'hA0); exp_q.push_back(8'h60);
        wait_done(40);
        check("t2_grant", 32'(a_grant_id), 32'd0);
        check("t2_ptr", 32'(a_dbg_ptr), 32'd1);

        // Reset in the middle of a packet
        load(2, 8'h81, 1'b0);
        load(2, 8'h82, 1'b0);
        load(2, 8'h83, 1'b1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h81);
        step(); step(); step(); step();
        check("t5_in_data", 32'(a_dbg_state), 32'd2);
        check("t5_dv_before", 32'(a_if.tx_dv), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_dv", 32'(a_if.tx_dv), 32'd0);
        check("t5_rst_busy", 32'(a_busy), 32'd0);
        check("t5_rst_grant", 32'(a_grant_id), 32'd0);
        check("t5_rst_ptr", 32'(a_dbg_ptr), 32'd0);
        flush();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_rel_grant", 32'(a_grant_id), 32'd0);
        check("t5_rel_ptr", 32'(a_dbg_ptr), 32'd0);
        check("t5_rel_state", 32'(a_dbg_state), 32'd0);

        // Backpressure: FIFO full for five cycles after the first payload byte
        load(1, 8'h31, 1'b0);
        load(1, 8'h32, 1'b0);
        load(1, 8'h33, 1'b1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h31);
        exp_q.push_back(8'h32); exp_q.push_back(8'h33);
        step(); step(); step(); step();
        a_if.tx_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t3_full_dv", 32'(a_if.tx_dv), 32'd0);
            check("t3_full_ready", 32'(a_if.req_ready), 32'd0);
            step();
        end
        a_if.tx_full = 1'b0;
        wait_done(20);
        check("t3_no_abort", 32'(abort_seen), 32'd0);

        // Watchdog: requester 1 goes silent after one byte, requester 3 waits
        do_reset();
        load(1, 8'h41, 1'b0);
        load(3, 8'h71, 1'b1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h41);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h71);
        step(); step(); step(); step();
        for (int k = 0; k < 8; k++) begin
            check("t4_no_abort_yet", 32'(a_pkt_abort), 32'd0);
            step();
        end
        check("t4_abort_pulse", 32'(a_pkt_abort), 32'd1);
        check("t4_abort_idle", 32'(a_busy), 32'd0);
        step();
        check("t4_abort_single", 32'(a_pkt_abort), 32'd0);
        check("t4_next_grant", 32'(a_grant_id), 32'd3);
        wait_done(10);
        check("t4_abort_count", 32'(abort_seen), 32'd1);

        // No header, pointer wrap from requester 3 to requester 0
        b_if.req_valid = 4'b1000;
        b_if.req_data[31:24] = 8'hD3;
        b_if.req_last = 4'b1000;
        #1;
        check("t6_arb_busy", 32'(b_busy), 32'd0);
        @(posedge clk); #1;
        b_if.req_valid = 4'b1001;
        b_if.req_data[7:0] = 8'hC0;
        b_if.req_last = 4'b1001;
        #1;
        check("t6_r3_dv", 32'(b_if.tx_dv), 32'd1);
        check("t6_r3_byte", 32'(b_if.tx_data), 32'hD3);
        check("t6_r3_ready", 32'(b_if.req_ready), 32'h8);
        @(posedge clk); #1;
        b_if.req_valid = 4'b0001;
        b_if.req_last = 4'b0001;
        #1;
        check("t6_wrap_ptr", 32'(b_dbg_ptr), 32'd0);
        check("t6_gap_dv", 32'(b_if.tx_dv), 32'd0);
        @(posedge clk); #2;
        check("t6_r0_grant", 32'(b_grant_id), 32'd0);
        check("t6_r0_dv", 32'(b_if.tx_dv), 32'd1);
        check("t6_r0_byte", 32'(b_if.tx_data), 32'hC0);
        @(posedge clk); #1;
        b_if.req_valid = 4'b0000;
        #1;
        check("t6_end_busy", 32'(b_busy), 32'd0);
        check("t6_end_ptr", 32'(b_dbg_ptr), 32'd1);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
